// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state encoding and widths for the Booth multiplier sequencer
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } booth_state_t;

    localparam int BOOTH_WIDTH  = 4;
    localparam int BOOTH_PWIDTH = 8;

endpackage

// File: rtl/booth_seq_timer.sv
// rtl/booth_seq_timer.sv - RUN-state cycle counter that flags the last allowed cycle
module booth_seq_timer #(
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    // count enabled cycles since the last clear, saturating on the final cycle
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    // the cycle carrying count == LIMIT-1 is the LIMIT-th enabled cycle
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/booth_mul_sequencer.sv
// rtl/booth_mul_sequencer.sv - operand/result sequencer for the radix-4 Booth multiplier; optional RUN timeout under BOOTH_SEQ_TIMEOUT_EN
module booth_mul_sequencer
    import booth_pkg::*;
#(
    parameter int WIDTH          = BOOTH_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 mul_reset,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p,
    input  logic                 mul_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 out_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("booth_mul_sequencer: TIMEOUT_CYCLES must be at least 2");
    end

    booth_state_t state;
    logic         first_run;
    logic         timed_out;

`ifdef BOOTH_SEQ_TIMEOUT_EN
    booth_seq_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == CLEAR),
        .enable (state == RUN),
        .expired(timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    // multiplier is cleared while we are in reset and for the single CLEAR cycle of every run
    assign mul_reset = reset || (state == CLEAR);
    assign out_valid = (state == DONE);
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);

    // control FSM: accept operands, clear and start the multiplier, capture and hand off the product
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            first_run <= 1'b0;
            out_p     <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mul_a <= in_a;
                        mul_b <= in_b;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    mul_start <= 1'b1;
                    first_run <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    first_run <= 1'b0;
                    // the ready flag seen on the first RUN cycle is left over from before the clear
                    if (!first_run && mul_ready) begin
                        out_p     <= mul_p;
                        out_err   <= 1'b0;
                        mul_start <= 1'b0;
                        state     <= DONE;
                    end else if (timed_out) begin
                        out_p     <= '0;
                        out_err   <= 1'b1;
                        mul_start <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            mul_a <= in_a;
                            mul_b <= in_b;
                            state <= CLEAR;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
